// File: rtl/cpu_pkg.sv
// Shared CPU/sequencer definitions: CPU state encodings, opcodes, sequencer FSM
// encoding and sizing constants for the program sequencer.
package cpu_pkg;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int IW      = 9;
  localparam int OPW     = 3;
  localparam int OW      = IW - OPW;
  localparam int TIMEOUT = 64;
  localparam int WDW     = $clog2(TIMEOUT + 1);

  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

  localparam logic [4:0] ST_FETCH = 5'b00000;
  localparam logic [4:0] ST_LOAD  = 5'b00001;
  localparam logic [4:0] ST_MOV   = 5'b00010;
  localparam logic [4:0] ST_ALU1  = 5'b00011;
  localparam logic [4:0] ST_ALU2  = 5'b00100;
  localparam logic [4:0] ST_ALU3  = 5'b00101;
  localparam logic [4:0] ST_WB    = 5'b10000;
  localparam logic [4:0] ST_RST   = 5'b11111;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_RUN   = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // Lengths beyond the memory depth are clipped so pc can never leave the array.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction
endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x IW register file, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int D = DEPTH,
  parameter int A = AW,
  parameter int W = IW
) (
  input  logic         i_clk,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] r_mem [D];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: feeds opcodes/operands from a small program store to the CPU
// control FSM, pulsing start and advancing on each FETCH; flags done, timeout and CPU reset.
module prog_sequencer
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [IW-1:0]    load_data,
  input  logic [AW:0]      prog_len,
  input  logic             run,
  input  logic [4:0]       cpu_state,
  output logic             start,
  output logic [2:0]       code,
  output logic [OW-1:0]    operand,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output seq_state_e       state_dbg
);
  seq_state_e        r_state, w_state_nxt;
  logic [AW:0]       r_len, w_len_nxt;
  logic [AW-1:0]     r_pc, w_pc_nxt;
  logic [2:0]        r_code, w_code_nxt;
  logic [OW-1:0]     r_operand, w_operand_nxt;
  logic              r_err, w_err_nxt;
  logic [WDW-1:0]    r_wdog, w_wdog_nxt;
  logic              w_we;
  logic [AW-1:0]     w_raddr;
  logic [IW-1:0]     w_rdata;
  logic              w_fetch;

  prog_mem #(.D(DEPTH), .A(AW), .W(IW)) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_fetch = (cpu_state == ST_FETCH);

  // Interface: code/operand are valid while busy; the CPU consumes the presented
  // word in each cycle it sits in FETCH, and the next word appears one cycle later.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_pc_nxt      = r_pc;
    w_code_nxt    = r_code;
    w_operand_nxt = r_operand;
    w_err_nxt     = r_err;
    w_wdog_nxt    = r_wdog;
    w_we          = 1'b0;
    w_raddr       = r_pc + 1'b1;
    case (r_state)
      SEQ_IDLE, SEQ_DONE: begin
        w_raddr = '0;
        if (load_en) begin
          w_we = 1'b1;
        end else if (run) begin
          w_err_nxt  = 1'b0;
          w_wdog_nxt = '0;
          w_pc_nxt   = '0;
          if (prog_len == '0) begin
            w_state_nxt   = SEQ_DONE;
            w_code_nxt    = OP_NOP;
            w_operand_nxt = '0;
          end else begin
            w_state_nxt   = SEQ_START;
            w_len_nxt     = clamp_len(prog_len);
            w_code_nxt    = w_rdata[IW-1:OW];
            w_operand_nxt = w_rdata[OW-1:0];
          end
        end
      end
      SEQ_START: w_state_nxt = SEQ_RUN;
      SEQ_RUN, SEQ_DRAIN: begin
        w_wdog_nxt = w_fetch ? '0 : r_wdog + 1'b1;
        if ((cpu_state == ST_RST) || (r_wdog == WDW'(TIMEOUT))) begin
          w_err_nxt     = 1'b1;
          w_state_nxt   = SEQ_DONE;
          w_code_nxt    = OP_NOP;
          w_operand_nxt = '0;
        end else if (w_fetch) begin
          if (r_state == SEQ_DRAIN) begin
            w_state_nxt = SEQ_DONE;
          end else if (({1'b0, r_pc} + 1'b1) < r_len) begin
            w_pc_nxt      = r_pc + 1'b1;
            w_code_nxt    = w_rdata[IW-1:OW];
            w_operand_nxt = w_rdata[OW-1:0];
          end else begin
            w_state_nxt   = SEQ_DRAIN;
            w_code_nxt    = OP_NOP;
            w_operand_nxt = '0;
          end
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEQ_IDLE;
      r_len     <= '0;
      r_pc      <= '0;
      r_code    <= OP_NOP;
      r_operand <= '0;
      r_err     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_pc      <= w_pc_nxt;
      r_code    <= w_code_nxt;
      r_operand <= w_operand_nxt;
      r_err     <= w_err_nxt;
      r_wdog    <= w_wdog_nxt;
    end
  end

  assign start     = (r_state == SEQ_START);
  assign busy      = (r_state == SEQ_START) || (r_state == SEQ_RUN) || (r_state == SEQ_DRAIN);
  assign done      = (r_state == SEQ_DONE);
  assign err       = r_err;
  assign code      = r_code;
  assign operand   = r_operand;
  assign pc        = r_pc;
  assign state_dbg = r_state;
endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: single-cycle vector table in IDLE/DONE plus multi-cycle
// sequences driven against a behavioural CPU model that checks every fetched word.
module tb_prog_sequencer;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_en = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [IW-1:0]   load_data = '0;
  logic [AW:0]     prog_len = '0;
  logic            run = 1'b0;
  logic [4:0]      cpu_state = ST_RST;
  logic            start;
  logic [2:0]      code;
  logic [OW-1:0]   operand;
  logic [AW-1:0]   pc;
  logic            busy, done, err;
  seq_state_e      state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int cpu_mode = 0;            // 0 normal, 1 stall away from FETCH, 2 force RST
  logic [4:0]    cpu_pend = ST_RST;
  logic [IW-1:0] cpu_exp;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] tb_mem [DEPTH];

  prog_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .prog_len  (prog_len),
    .run       (run),
    .cpu_state (cpu_state),
    .start     (start),
    .code      (code),
    .operand   (operand),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (start) start_cnt++;
  end

  // CPU model: register-like behaviour emulated on the falling edge, one cycle delayed.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cpu_state = ST_RST;
      cpu_pend  = ST_RST;
    end else begin
      cpu_state = cpu_pend;
      if (cpu_state == ST_FETCH) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fetch: got word 0x%0h with no expected word", {code, operand});
        end else begin
          cpu_exp = exp_q.pop_front();
          check("fetch_word", {23'd0, code, operand}, {23'd0, cpu_exp});
        end
      end
      if (start)              cpu_pend = ST_FETCH;
      else if (cpu_mode == 2) cpu_pend = ST_RST;
      else if (cpu_mode == 1) cpu_pend = ST_ALU1;
      else begin
        case (cpu_state)
          ST_FETCH: cpu_pend = (code == OP_NOP) ? ST_RST : ST_ALU1;
          ST_ALU1:  cpu_pend = ST_ALU2;
          ST_ALU2:  cpu_pend = ST_WB;
          ST_WB:    cpu_pend = ST_FETCH;
          default:  cpu_pend = cpu_state;
        endcase
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic start_prog(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(tb_mem[i]);
    exp_q.push_back({OP_NOP, {OW{1'b0}}});
    run = 1'b1; prog_len = (AW+1)'(len);
    @(negedge clk);
    run = 1'b0;
    check("start_pulse", start, 1);
    check("busy_in_start", busy, 1);
    check("first_word", {23'd0, code, operand}, {23'd0, tb_mem[0]});
    check("err_cleared_on_run", err, 0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic wait_pc(input logic [AW-1:0] target, input int budget);
    int c;
    c = 0;
    while (pc != target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("pc_reached", pc, target);
  endtask

  typedef struct {
    logic          load_en;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
    logic          run;
    logic [AW:0]   len;
    logic          exp_start;
    logic          exp_busy;
    logic          exp_done;
    logic [2:0]    exp_code;
    seq_state_e    exp_state;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, s0, wrap;
    logic [AW-1:0] last_pc;

    vecs[0] = '{1'b1, 4'd0, {OP_LOAD, 6'd5},  1'b1, 5'd3, 1'b0, 1'b0, 1'b0, OP_NOP, SEQ_IDLE};
    vecs[1] = '{1'b1, 4'd1, {OP_MOV,  6'd12}, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, OP_NOP, SEQ_IDLE};
    vecs[2] = '{1'b1, 4'd2, {OP_ADD,  6'd33}, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, OP_NOP, SEQ_IDLE};
    vecs[3] = '{1'b0, 4'd0, 9'd0,             1'b1, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, SEQ_DONE};
    vecs[4] = '{1'b0, 4'd0, 9'd0,             1'b0, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, SEQ_DONE};
    vecs[5] = '{1'b1, 4'd3, {OP_SUB,  6'd7},  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, OP_NOP, SEQ_DONE};

    // reset
    repeat (3) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", code, OP_NOP);
    check("rst_operand", operand, 0);
    check("rst_pc", pc, 0);
    check("rst_state", state_dbg, SEQ_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // table: load+run collision, loads, zero-length run, load while DONE
    for (int i = 0; i < 6; i++) begin
      load_en = vecs[i].load_en; load_addr = vecs[i].addr; load_data = vecs[i].data;
      run = vecs[i].run; prog_len = vecs[i].len;
      @(negedge clk);
      if (vecs[i].load_en) tb_mem[vecs[i].addr] = vecs[i].data;
      load_en = 1'b0; run = 1'b0;
      check($sformatf("vec%0d_start", i), start, vecs[i].exp_start);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
      check($sformatf("vec%0d_state", i), state_dbg, vecs[i].exp_state);
    end
    check("len0_no_start", start_cnt, 0);

    // three-instruction program; a run pulse while busy must be ignored
    s0 = start_cnt;
    start_prog(3);
    @(negedge clk);
    run = 1'b1; prog_len = 5'd1;
    @(negedge clk);
    run = 1'b0;
    check("run_ignored_start", start, 0);
    check("run_ignored_busy", busy, 1);
    wait_done(100, cyc);
    check("prog3_code_nop", code, OP_NOP);
    check("prog3_err", err, 0);
    check("prog3_pc", pc, 2);
    check("prog3_one_start", start_cnt - s0, 1);
    check("prog3_q_empty", exp_q.size(), 0);

    // watchdog: CPU stalls after its first FETCH
    cpu_mode = 1;
    start_prog(3);
    wait_done(200, cyc);
    check("wdog_latency", cyc, 67);
    check("wdog_err", err, 1);
    check("wdog_code", code, OP_NOP);
    check("wdog_operand", operand, 0);
    exp_q.delete();
    cpu_mode = 2;
    repeat (2) @(negedge clk);
    cpu_mode = 0;
    check("err_sticky", err, 1);
    start_prog(1);
    wait_done(50, cyc);
    check("rerun_err_clear", err, 0);

    // CPU reset seen mid-run; load while busy must not reach memory
    load_word(4'd4, {OP_AND, 6'd9});
    start_prog(5);
    @(negedge clk);
    load_en = 1'b1; load_addr = 4'd0; load_data = {OP_AND, 6'd63}; run = 1'b1; prog_len = 5'd2;
    @(negedge clk);
    load_en = 1'b0; run = 1'b0;
    wait_pc(4'd2, 50);
    cpu_mode = 2;
    wait_done(20, cyc);
    check("cpurst_err", err, 1);
    check("cpurst_code", code, OP_NOP);
    check("cpurst_busy", busy, 0);
    exp_q.delete();
    cpu_mode = 0;
    @(negedge clk);
    start_prog(1);
    wait_done(50, cyc);

    // asynchronous reset mid-program, then rerun from pc 0
    start_prog(5);
    wait_pc(4'd2, 50);
    rst_n = 1'b0;
    #1;
    check("midrst_start", start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_code", code, OP_NOP);
    check("midrst_operand", operand, 0);
    check("midrst_pc", pc, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", state_dbg, SEQ_IDLE);
    start_prog(5);
    wait_done(100, cyc);
    check("rerun_pc", pc, 4);
    check("rerun_err", err, 0);

    // full-depth program with random contents
    for (int i = 0; i < DEPTH; i++)
      load_word(AW'(i), {3'($urandom_range(0, 4)), 6'($urandom_range(0, 63))});
    start_prog(DEPTH);
    wrap = 0;
    last_pc = pc;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pc < last_pc) wrap = 1;
      last_pc = pc;
    end
    check("full_done", done, 1);
    check("full_pc_sat", pc, DEPTH - 1);
    check("full_no_wrap", wrap, 0);
    check("full_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
